// File: rtl/rf_seq_pkg.sv
// Shared types for the RF sequence scheduler: FSM states, grant sources and
// configuration register addresses.
package rf_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEAD,
    P1,
    GAP1,
    P2,
    GAP2,
    P3,
    RPULSE,
    HOLD
  } state_e;

  typedef enum logic {
    SRC_MZ   = 1'b0,
    SRC_RABI = 1'b1
  } src_e;

  localparam logic [2:0] CFG_DEAD       = 3'd0;
  localparam logic [2:0] CFG_PI2        = 3'd1;
  localparam logic [2:0] CFG_PI         = 3'd2;
  localparam logic [2:0] CFG_WAIT       = 3'd3;
  localparam logic [2:0] CFG_HOLD       = 3'd4;
  localparam logic [2:0] CFG_RABI_STEP  = 3'd5;
  localparam logic [2:0] CFG_RABI_RESET = 3'd6;

  // RF is driven only while one of these states is current.
  function automatic logic is_pulse(input state_e s);
    return s inside {P1, P2, P3, RPULSE};
  endfunction

endpackage

// File: rtl/trig_edge_sync.sv
// Two-flop synchroniser for an asynchronous trigger pin followed by a
// rising-edge detector; rise_pulse is high for one clk cycle per edge.
module trig_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // sync_q[1] is the first metastability-safe sample; sync_q[2] is its history.
  assign rise_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/rf_sequence_scheduler.sv
// Shares one RF switch between the Mach-Zehnder pulse sequence and the Rabi
// scan pulse: trigger sync, round-robin arbitration, phase timing, config regs.
//
// state  | meaning
// IDLE   | waiting for a pending request; arbitration happens here
// DEAD   | MZ pre-sequence dead time, rf low
// P1     | MZ first pi/2 pulse, rf high
// GAP1   | MZ free evolution, rf low
// P2     | MZ pi pulse, rf high
// GAP2   | MZ free evolution, rf low
// P3     | MZ closing pi/2 pulse, rf high
// RPULSE | Rabi pulse of rabi_len cycles, rf high
// HOLD   | post-run hold for the Arduino pin turnaround, rf low
module rf_sequence_scheduler
  import rf_seq_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DEAD_CYC  = 400,
  parameter int PI2_CYC   = 333,
  parameter int PI_CYC    = 666,
  parameter int WAIT_CYC  = 66600,
  parameter int HOLD_CYC  = 33300,
  parameter int RABI_INIT = 66,
  parameter int RABI_STEP = 66,
  parameter int RABI_MAX  = 66000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mz_trig,
  input  logic             rabi_trig,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic             rf,
  output logic             mz_active,
  output logic             rabi_active,
  output logic             busy,
  output logic             seq_done,
  output logic [CNT_W-1:0] rabi_len
);

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEAD_DEF    = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] PI2_DEF     = CNT_W'(PI2_CYC);
  localparam logic [CNT_W-1:0] PI_DEF      = CNT_W'(PI_CYC);
  localparam logic [CNT_W-1:0] WAIT_DEF    = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] HOLD_DEF    = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] STEP_DEF    = CNT_W'(RABI_STEP);
  localparam logic [CNT_W-1:0] RABI_INIT_W = CNT_W'(RABI_INIT);
  localparam logic [CNT_W:0]   RABI_MAX_W  = (CNT_W+1)'(RABI_MAX);

  // Down-counter load value: a phase of length N lasts N cycles, N=0 acts as 1.
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - ONE;
  endfunction

  logic mz_rise;
  logic rabi_rise;

  trig_edge_sync u_mz_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (mz_trig),
    .rise_pulse (mz_rise)
  );

  trig_edge_sync u_rabi_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (rabi_trig),
    .rise_pulse (rabi_rise)
  );

  state_e           state_q, state_d;
  src_e             src_q, src_d;
  src_e             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mz_pend_q, mz_pend_d;
  logic             rabi_pend_q, rabi_pend_d;
  logic [CNT_W-1:0] cfg_dead_q, cfg_dead_d;
  logic [CNT_W-1:0] cfg_pi2_q, cfg_pi2_d;
  logic [CNT_W-1:0] cfg_pi_q, cfg_pi_d;
  logic [CNT_W-1:0] cfg_wait_q, cfg_wait_d;
  logic [CNT_W-1:0] cfg_hold_q, cfg_hold_d;
  logic [CNT_W-1:0] cfg_step_q, cfg_step_d;
  logic [CNT_W-1:0] act_pi2_q, act_pi2_d;
  logic [CNT_W-1:0] act_pi_q, act_pi_d;
  logic [CNT_W-1:0] act_wait_q, act_wait_d;
  logic [CNT_W-1:0] act_hold_q, act_hold_d;
  logic [CNT_W-1:0] rabi_len_q, rabi_len_d;
  logic             rabi_sup_q, rabi_sup_d;
  logic             rf_q, rf_d;
  logic             mz_act_q, mz_act_d;
  logic             rabi_act_q, rabi_act_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             grant_mz;
  logic             grant_rabi;
  logic [CNT_W:0]   rsum;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    cfg_dead_d  = cfg_dead_q;
    cfg_pi2_d   = cfg_pi2_q;
    cfg_pi_d    = cfg_pi_q;
    cfg_wait_d  = cfg_wait_q;
    cfg_hold_d  = cfg_hold_q;
    cfg_step_d  = cfg_step_q;
    act_pi2_d   = act_pi2_q;
    act_pi_d    = act_pi_q;
    act_wait_d  = act_wait_q;
    act_hold_d  = act_hold_q;
    rabi_len_d  = rabi_len_q;
    rabi_sup_d  = rabi_sup_q;
    done_d      = 1'b0;
    grant_mz    = 1'b0;
    grant_rabi  = 1'b0;
    rsum        = {1'b0, rabi_len_q} + {1'b0, cfg_step_q};

    case (state_q)
      IDLE: begin
        // Round-robin only matters when both are pending.
        if (mz_pend_q && (!rabi_pend_q || last_q == SRC_RABI)) begin
          grant_mz = 1'b1;
        end else if (rabi_pend_q) begin
          grant_rabi = 1'b1;
        end

        if (grant_mz) begin
          state_d    = DEAD;
          cnt_d      = ld(cfg_dead_q);
          src_d      = SRC_MZ;
          last_d     = SRC_MZ;
          act_pi2_d  = cfg_pi2_q;
          act_pi_d   = cfg_pi_q;
          act_wait_d = cfg_wait_q;
          act_hold_d = cfg_hold_q;
        end else if (grant_rabi) begin
          state_d    = RPULSE;
          cnt_d      = ld(rabi_len_q);
          src_d      = SRC_RABI;
          last_d     = SRC_RABI;
          act_hold_d = cfg_hold_q;
          rabi_sup_d = 1'b0;
        end
      end

      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          case (state_q)
            DEAD:   begin state_d = P1;   cnt_d = ld(act_pi2_q);  end
            P1:     begin state_d = GAP1; cnt_d = ld(act_wait_q); end
            GAP1:   begin state_d = P2;   cnt_d = ld(act_pi_q);   end
            P2:     begin state_d = GAP2; cnt_d = ld(act_wait_q); end
            GAP2:   begin state_d = P3;   cnt_d = ld(act_pi2_q);  end
            P3:     begin state_d = HOLD; cnt_d = ld(act_hold_q); end
            RPULSE: begin
              state_d = HOLD;
              cnt_d   = ld(act_hold_q);
              if (!rabi_sup_q) begin
                rabi_len_d = (rsum > RABI_MAX_W) ? RABI_INIT_W : rsum[CNT_W-1:0];
              end
            end
            HOLD: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase

    // Writes land after the FSM so a same-cycle grant still snapshots the old value.
    if (cfg_we) begin
      case (cfg_addr)
        CFG_DEAD:      cfg_dead_d = cfg_wdata;
        CFG_PI2:       cfg_pi2_d  = cfg_wdata;
        CFG_PI:        cfg_pi_d   = cfg_wdata;
        CFG_WAIT:      cfg_wait_d = cfg_wdata;
        CFG_HOLD:      cfg_hold_d = cfg_wdata;
        CFG_RABI_STEP: cfg_step_d = cfg_wdata;
        CFG_RABI_RESET: begin
          rabi_len_d = RABI_INIT_W;
          if (state_q == RPULSE || grant_rabi) begin
            rabi_sup_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    mz_pend_d   = (mz_pend_q & ~grant_mz) | mz_rise;
    rabi_pend_d = (rabi_pend_q & ~grant_rabi) | rabi_rise;

    rf_d       = is_pulse(state_d);
    busy_d     = (state_d != IDLE);
    mz_act_d   = busy_d && (src_d == SRC_MZ);
    rabi_act_d = busy_d && (src_d == SRC_RABI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_RABI;
      last_q      <= SRC_RABI;
      cnt_q       <= '0;
      mz_pend_q   <= 1'b0;
      rabi_pend_q <= 1'b0;
      cfg_dead_q  <= DEAD_DEF;
      cfg_pi2_q   <= PI2_DEF;
      cfg_pi_q    <= PI_DEF;
      cfg_wait_q  <= WAIT_DEF;
      cfg_hold_q  <= HOLD_DEF;
      cfg_step_q  <= STEP_DEF;
      act_pi2_q   <= PI2_DEF;
      act_pi_q    <= PI_DEF;
      act_wait_q  <= WAIT_DEF;
      act_hold_q  <= HOLD_DEF;
      rabi_len_q  <= RABI_INIT_W;
      rabi_sup_q  <= 1'b0;
      rf_q        <= 1'b0;
      mz_act_q    <= 1'b0;
      rabi_act_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mz_pend_q   <= mz_pend_d;
      rabi_pend_q <= rabi_pend_d;
      cfg_dead_q  <= cfg_dead_d;
      cfg_pi2_q   <= cfg_pi2_d;
      cfg_pi_q    <= cfg_pi_d;
      cfg_wait_q  <= cfg_wait_d;
      cfg_hold_q  <= cfg_hold_d;
      cfg_step_q  <= cfg_step_d;
      act_pi2_q   <= act_pi2_d;
      act_pi_q    <= act_pi_d;
      act_wait_q  <= act_wait_d;
      act_hold_q  <= act_hold_d;
      rabi_len_q  <= rabi_len_d;
      rabi_sup_q  <= rabi_sup_d;
      rf_q        <= rf_d;
      mz_act_q    <= mz_act_d;
      rabi_act_q  <= rabi_act_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rf          = rf_q;
  assign mz_active   = mz_act_q;
  assign rabi_active = rabi_act_q;
  assign busy        = busy_q;
  assign seq_done    = done_q;
  assign rabi_len    = rabi_len_q;

endmodule

// File: tb/tb_rf_sequence_scheduler.sv
// Scenario bench for rf_sequence_scheduler: short timing parameters, randomized
// configs, and a reference model of the rf waveform as phase-length lists.
module tb_rf_sequence_scheduler;

  localparam int CW      = 32;
  localparam int P_DEAD  = 4;
  localparam int P_PI2   = 3;
  localparam int P_PI    = 6;
  localparam int P_WAIT  = 10;
  localparam int P_HOLD  = 7;
  localparam int P_RINIT = 5;
  localparam int P_RSTEP = 5;
  localparam int P_RMAX  = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mz_trig = 1'b0;
  logic          rabi_trig = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = 3'd0;
  logic [CW-1:0] cfg_wdata = '0;
  logic          rf, mz_active, rabi_active, busy, seq_done;
  logic [CW-1:0] rabi_len;

  int errors = 0;
  int checks = 0;

  // Reference model: configuration as seen by the next grant, next Rabi length, last grant.
  int m_dead, m_pi2, m_pi, m_wait, m_hold, m_step, m_rlen;
  int m_last;  // 0 = MZ, 1 = Rabi

  int   segs[$];
  int   cap_wait;
  logic cap_rf0, cap_mz, cap_rabi, cap_done;

  rf_sequence_scheduler #(
    .CNT_W(CW), .DEAD_CYC(P_DEAD), .PI2_CYC(P_PI2), .PI_CYC(P_PI), .WAIT_CYC(P_WAIT),
    .HOLD_CYC(P_HOLD), .RABI_INIT(P_RINIT), .RABI_STEP(P_RSTEP), .RABI_MAX(P_RMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mz_trig(mz_trig), .rabi_trig(rabi_trig),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .rf(rf), .mz_active(mz_active), .rabi_active(rabi_active), .busy(busy),
    .seq_done(seq_done), .rabi_len(rabi_len)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic int ph(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic string mz_exp();
    return $sformatf("%0d %0d %0d %0d %0d %0d %0d ", ph(m_dead), ph(m_pi2), ph(m_wait),
                     ph(m_pi), ph(m_wait), ph(m_pi2), ph(m_hold));
  endfunction

  function automatic string rabi_exp();
    return $sformatf("%0d %0d ", ph(m_rlen), ph(m_hold));
  endfunction

  function automatic int next_rlen();
    int r;
    r = m_rlen + m_step;
    return (r > P_RMAX) ? P_RINIT : r;
  endfunction

  function automatic string q2s(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  task automatic model_reset();
    m_dead = P_DEAD; m_pi2 = P_PI2; m_pi = P_PI; m_wait = P_WAIT; m_hold = P_HOLD;
    m_step = P_RSTEP; m_rlen = P_RINIT; m_last = 1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    case (a)
      3'd0: m_dead = d;
      3'd1: m_pi2 = d;
      3'd2: m_pi = d;
      3'd3: m_wait = d;
      3'd4: m_hold = d;
      3'd5: m_step = d;
      3'd6: m_rlen = P_RINIT;
      default: ;
    endcase
  endtask

  task automatic fire(input logic mz, input logic rb);
    @(negedge clk);
    mz_trig = mz; rabi_trig = rb;
  endtask

  // Waits for busy, then records rf run lengths until busy drops. act 1: cfg write
  // at run cycle k; act 2: two mz_trig edges from cycle k; act 3: one rabi_trig edge.
  task automatic capture(input int act, input int k, input logic [2:0] a, input int d);
    int cyc, len;
    logic lvl;
    segs.delete();
    cap_wait = 0; cap_done = 1'b0;
    while (busy !== 1'b1 && cap_wait < 200) begin
      @(negedge clk);
      cap_wait++;
      mz_trig = 1'b0; rabi_trig = 1'b0;
    end
    if (busy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL start_timeout busy=%b waited=%0d", busy, cap_wait);
      return;
    end
    cyc = 0; len = 0; lvl = rf;
    cap_rf0 = rf; cap_mz = mz_active; cap_rabi = rabi_active;
    while (busy === 1'b1 && cyc < 1000) begin
      if (rf !== lvl) begin segs.push_back(len); lvl = rf; len = 0; end
      len++;
      cfg_we = 1'b0;
      if (act == 1 && cyc == k) begin cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; end
      if (act == 2) mz_trig = (cyc >= k && cyc < k + 12 && ((cyc - k) / 3) % 2 == 0);
      if (act == 3) rabi_trig = (cyc >= k && cyc < k + 3);
      @(negedge clk);
      cyc++;
    end
    cfg_we = 1'b0; mz_trig = 1'b0; rabi_trig = 1'b0;
    segs.push_back(len);
    if (busy === 1'b1) begin
      checks++; errors++;
      $display("FAIL run_timeout busy still high after %0d cycles", cyc);
    end
    cap_done = (seq_done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (rf !== 1'b0) begin errors++; $display("FAIL reset_rf got=%b exp=0", rf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mz_active !== 1'b0) begin errors++; $display("FAIL reset_mz_active got=%b exp=0", mz_active); end
    checks++; if (rabi_active !== 1'b0) begin errors++; $display("FAIL reset_rabi_active got=%b exp=0", rabi_active); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done got=%b exp=0", seq_done); end
    checks++; if (rabi_len !== P_RINIT) begin errors++; $display("FAIL reset_rabi_len got=%0d exp=%0d", rabi_len, P_RINIT); end
  endtask

  task automatic test_mz();
    string exp;
    for (int it = 0; it < 4; it++) begin
      if (it > 0) begin
        cfg_write(3'd0, (it == 1) ? 0 : int'($urandom_range(0, 8)));
        cfg_write(3'd1, int'($urandom_range(0, 6)));
        cfg_write(3'd2, int'($urandom_range(0, 9)));
        cfg_write(3'd3, int'($urandom_range(1, 12)));
        cfg_write(3'd4, (it == 1) ? 0 : int'($urandom_range(0, 8)));
      end
      exp = mz_exp();
      fire(1'b1, 1'b0);
      capture(0, 0, 3'd0, 0);
      m_last = 0;
      checks++; if (cap_wait !== 4) begin errors++; $display("FAIL mz_latency it=%0d got=%0d exp=4", it, cap_wait); end
      checks++; if (cap_rf0 !== 1'b0 || cap_mz !== 1'b1 || cap_rabi !== 1'b0) begin errors++; $display("FAIL mz_flags it=%0d rf0=%b mz=%b rabi=%b exp 0 1 0", it, cap_rf0, cap_mz, cap_rabi); end
      checks++; if (q2s(segs) != exp) begin errors++; $display("FAIL mz_phases it=%0d got='%s' exp='%s'", it, q2s(segs), exp); end
      checks++; if (cap_done !== 1'b1) begin errors++; $display("FAIL mz_seq_done it=%0d got=%b exp=1", it, cap_done); end
    end
  endtask

  task automatic test_rabi();
    string exp;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) cfg_write(3'd5, int'($urandom_range(1, 9)));
      exp = rabi_exp();
      fire(1'b0, 1'b1);
      capture(0, 0, 3'd0, 0);
      m_last = 1;
      m_rlen = next_rlen();
      checks++; if (cap_rf0 !== 1'b1 || cap_rabi !== 1'b1 || cap_mz !== 1'b0) begin errors++; $display("FAIL rabi_flags i=%0d rf0=%b rabi=%b mz=%b exp 1 1 0", i, cap_rf0, cap_rabi, cap_mz); end
      checks++; if (q2s(segs) != exp || cap_done !== 1'b1) begin errors++; $display("FAIL rabi_pulse i=%0d got='%s' done=%b exp='%s' done=1", i, q2s(segs), cap_done, exp); end
      checks++; if (rabi_len !== m_rlen) begin errors++; $display("FAIL rabi_len_next i=%0d got=%0d exp=%0d", i, rabi_len, m_rlen); end
    end
    // RABI_RESET mid-pulse: pulse keeps its length, no increment afterwards.
    exp = rabi_exp();
    fire(1'b0, 1'b1);
    capture(1, 1, 3'd6, 0);
    m_last = 1;
    m_rlen = P_RINIT;
    checks++; if (q2s(segs) != exp) begin errors++; $display("FAIL rabi_reset_pulse got='%s' exp='%s'", q2s(segs), exp); end
    checks++; if (rabi_len !== m_rlen) begin errors++; $display("FAIL rabi_reset_len got=%0d exp=%0d", rabi_len, m_rlen); end
  endtask

  task automatic test_arbitration();
    string exp;
    logic first_mz;
    for (int r = 0; r < 3; r++) begin
      if (r == 1) begin
        exp = mz_exp();
        fire(1'b1, 1'b0);
        capture(0, 0, 3'd0, 0);
        m_last = 0;
        checks++; if (q2s(segs) != exp) begin errors++; $display("FAIL arb_pre_mz got='%s' exp='%s'", q2s(segs), exp); end
      end
      first_mz = (m_last == 1);
      exp = first_mz ? mz_exp() : rabi_exp();
      fire(1'b1, 1'b1);
      capture(0, 0, 3'd0, 0);
      checks++; if (cap_mz !== first_mz || q2s(segs) != exp) begin errors++; $display("FAIL arb_first r=%0d mz=%b exp_mz=%b got='%s' exp='%s'", r, cap_mz, first_mz, q2s(segs), exp); end
      if (first_mz) m_last = 0; else begin m_last = 1; m_rlen = next_rlen(); end
      exp = first_mz ? rabi_exp() : mz_exp();
      capture(0, 0, 3'd0, 0);
      checks++; if (cap_wait !== 1) begin errors++; $display("FAIL arb_second_start r=%0d got=%0d exp=1", r, cap_wait); end
      checks++; if (cap_mz !== !first_mz || q2s(segs) != exp) begin errors++; $display("FAIL arb_second r=%0d mz=%b exp_mz=%b got='%s' exp='%s'", r, cap_mz, !first_mz, q2s(segs), exp); end
      if (first_mz) begin m_last = 1; m_rlen = next_rlen(); end else m_last = 0;
    end
  endtask

  task automatic test_cfg_during_run();
    string exp;
    int newp;
    cfg_write(3'd0, P_DEAD); cfg_write(3'd1, P_PI2); cfg_write(3'd2, P_PI);
    cfg_write(3'd3, P_WAIT); cfg_write(3'd4, P_HOLD);
    cfg_write(3'd7, 99);
    newp = int'($urandom_range(1, 9));
    exp = mz_exp();
    fire(1'b1, 1'b0);
    capture(1, ph(m_dead) + ph(m_pi2) + 2, 3'd1, newp);
    m_last = 0;
    checks++; if (q2s(segs) != exp) begin errors++; $display("FAIL cfg_midrun_current got='%s' exp='%s'", q2s(segs), exp); end
    m_pi2 = newp;
    exp = mz_exp();
    fire(1'b1, 1'b0);
    capture(0, 0, 3'd0, 0);
    m_last = 0;
    checks++; if (q2s(segs) != exp) begin errors++; $display("FAIL cfg_midrun_next got='%s' exp='%s'", q2s(segs), exp); end
  endtask

  task automatic test_back_to_back();
    string exp;
    logic saw;
    exp = mz_exp();
    fire(1'b1, 1'b0);
    capture(2, 2, 3'd0, 0);
    checks++; if (q2s(segs) != exp) begin errors++; $display("FAIL b2b_first got='%s' exp='%s'", q2s(segs), exp); end
    capture(0, 0, 3'd0, 0);
    checks++; if (cap_wait !== 1 || cap_mz !== 1'b1 || q2s(segs) != exp) begin errors++; $display("FAIL b2b_second wait=%0d mz=%b got='%s' exp wait=1 mz=1 '%s'", cap_wait, cap_mz, q2s(segs), exp); end
    saw = 1'b0;
    repeat (30) begin @(negedge clk); if (busy !== 1'b0) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL b2b_no_third got busy=1 exp idle"); end
  endtask

  task automatic test_reset_mid();
    string exp;
    logic saw;
    fire(1'b1, 1'b0);
    @(negedge clk);
    mz_trig = 1'b0;
    repeat (3) @(negedge clk);
    rabi_trig = 1'b1;
    @(negedge clk);
    rabi_trig = 1'b0;
    repeat (ph(m_dead) + ph(m_pi2) + ph(m_wait)) @(negedge clk);
    checks++; if (rf !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_in_p2 rf=%b busy=%b exp 1 1", rf, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (rf !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async rf=%b busy=%b exp 0 0", rf, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (rabi_len !== P_RINIT) begin errors++; $display("FAIL rstmid_rabi_len got=%0d exp=%0d", rabi_len, P_RINIT); end
    saw = 1'b0;
    repeat (20) begin @(negedge clk); if (busy !== 1'b0) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rstmid_pending got busy=1 exp idle"); end
    exp = mz_exp();
    fire(1'b1, 1'b0);
    capture(0, 0, 3'd0, 0);
    checks++; if (q2s(segs) != exp) begin errors++; $display("FAIL rstmid_defaults got='%s' exp='%s'", q2s(segs), exp); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mz();
    test_rabi();
    test_arbitration();
    test_cfg_during_run();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
